// File: rtl/matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : matmul_sequencer
// Purpose  : Command-level controller for the systolic matrix-multiply
//            datapath. Accepts one job at a time, holds the multiplier's
//            start/mode/dimension inputs for the whole job, captures the
//            result matrix and per-PE overflow flags on the finish strobe and
//            presents them on a valid/ready result port. Dimension checks
//            reject jobs larger than the array without starting it.
// Ports    : clk_i, rst_ni              clock, async active-low reset
//            cmd_*                      valid/ready job request (dims are N-1)
//            mul_start_o/mode/dims      drive the multiplier
//            mul_finish_i/flags/c       multiplier completion and result
//            res_*                      captured result, valid/ready
//            sticky_flags_o             flag OR across an accumulate chain
//            busy_o                     controller not idle
// Options  : MATMUL_SEQ_WATCHDOG_EN     when defined, a RUN job that sees no
//            finish within WATCHDOG_CYCLES cycles is aborted with res_err_o.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_sequencer #(
  parameter int DATA_WIDTH      = 8,
  parameter int BUS_WIDTH       = 16,
  parameter int WATCHDOG_CYCLES = 32
) (
  input  logic                                                              clk_i,
  input  logic                                                              rst_ni,
  input  logic                                                              cmd_valid_i,
  output logic                                                              cmd_ready_o,
  input  logic [1:0]                                                        cmd_n_dim_i,
  input  logic [1:0]                                                        cmd_k_dim_i,
  input  logic [1:0]                                                        cmd_m_dim_i,
  input  logic                                                              cmd_mode_i,
  output logic                                                              mul_start_o,
  output logic                                                              mul_mode_bit_o,
  output logic [1:0]                                                        mul_n_dim_o,
  output logic [1:0]                                                        mul_k_dim_o,
  output logic [1:0]                                                        mul_m_dim_o,
  input  logic                                                              mul_finish_i,
  input  logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0]           mul_flags_i,
  input  logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)*BUS_WIDTH-1:0] mul_c_matrix_i,
  output logic                                                              res_valid_o,
  input  logic                                                              res_ready_i,
  output logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)*BUS_WIDTH-1:0] res_c_matrix_o,
  output logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0]           res_flags_o,
  output logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0]           sticky_flags_o,
  output logic                                                              res_err_o,
  output logic                                                              busy_o
);

  localparam int         MAX_DIM     = BUS_WIDTH / DATA_WIDTH;
  localparam logic [1:0] C_DIM_LIMIT = 2'(MAX_DIM - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic w_accept;
  logic w_dim_bad;
  logic w_finish;
  logic w_wd_expire;

  assign w_accept  = cmd_valid_i && (r_state == ST_IDLE);
  assign w_dim_bad = (cmd_n_dim_i > C_DIM_LIMIT) || (cmd_k_dim_i > C_DIM_LIMIT) ||
                     (cmd_m_dim_i > C_DIM_LIMIT);
  // A finish strobe only counts while a job is running; stale strobes are dropped.
  assign w_finish  = mul_finish_i && (r_state == ST_RUN);

`ifdef MATMUL_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

  logic [WD_W-1:0] r_wd_cnt;

  // Counter is held at zero outside RUN, so it always starts from zero on entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wd_cnt <= '0;
    end else if (r_state != ST_RUN) begin
      r_wd_cnt <= '0;
    end else if (!w_wd_expire) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  assign w_wd_expire = (r_state == ST_RUN) && (r_wd_cnt == WD_W'(WATCHDOG_CYCLES));
`else
  logic w_unused_wd;

  assign w_wd_expire = 1'b0;
  assign w_unused_wd = (WATCHDOG_CYCLES != 0);
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a finish in the limit cycle takes priority over the watchdog.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = w_dim_bad ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_finish || w_wd_expire) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready_i) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Registered outputs. Handshake/status outputs are decoded from the next
  // state so they line up with the state register after each edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_ready_o    <= 1'b1;
      busy_o         <= 1'b0;
      mul_start_o    <= 1'b0;
      res_valid_o    <= 1'b0;
      mul_mode_bit_o <= 1'b0;
      mul_n_dim_o    <= 2'd0;
      mul_k_dim_o    <= 2'd0;
      mul_m_dim_o    <= 2'd0;
      res_c_matrix_o <= '0;
      res_flags_o    <= '0;
      sticky_flags_o <= '0;
      res_err_o      <= 1'b0;
    end else begin
      cmd_ready_o <= (w_state_next == ST_IDLE);
      busy_o      <= (w_state_next != ST_IDLE);
      mul_start_o <= (w_state_next == ST_RUN);
      res_valid_o <= (w_state_next == ST_DONE);

      if (w_accept) begin
        mul_mode_bit_o <= cmd_mode_i;
        mul_n_dim_o    <= cmd_n_dim_i;
        mul_k_dim_o    <= cmd_k_dim_i;
        mul_m_dim_o    <= cmd_m_dim_i;
        if (w_dim_bad) begin
          // Rejected job: error result, sticky flags untouched.
          res_c_matrix_o <= '0;
          res_flags_o    <= '0;
          res_err_o      <= 1'b1;
        end else if (!cmd_mode_i) begin
          // An overwrite job starts a new accumulate chain.
          sticky_flags_o <= '0;
        end
      end

      if (w_finish) begin
        res_c_matrix_o <= mul_c_matrix_i;
        res_flags_o    <= mul_flags_i;
        res_err_o      <= 1'b0;
        sticky_flags_o <= sticky_flags_o | mul_flags_i;
      end else if (w_wd_expire) begin
        res_c_matrix_o <= '0;
        res_flags_o    <= '0;
        res_err_o      <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_sequencer
// Purpose  : Directed self-checking bench for matmul_sequencer. The bench
//            plays the multiplier, pushes expected results to a scoreboard
//            when it drives finish, and pops them when res_valid_o appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_sequencer;

  localparam int NPE = 4;
  localparam int CW  = NPE * 16;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            cmd_valid_i = 1'b0;
  logic            cmd_ready_o;
  logic [1:0]      cmd_n_dim_i = 2'd0;
  logic [1:0]      cmd_k_dim_i = 2'd0;
  logic [1:0]      cmd_m_dim_i = 2'd0;
  logic            cmd_mode_i = 1'b0;
  logic            mul_start_o;
  logic            mul_mode_bit_o;
  logic [1:0]      mul_n_dim_o;
  logic [1:0]      mul_k_dim_o;
  logic [1:0]      mul_m_dim_o;
  logic            mul_finish_i = 1'b0;
  logic [NPE-1:0]  mul_flags_i = '0;
  logic [CW-1:0]   mul_c_matrix_i = '0;
  logic            res_valid_o;
  logic            res_ready_i = 1'b0;
  logic [CW-1:0]   res_c_matrix_o;
  logic [NPE-1:0]  res_flags_o;
  logic [NPE-1:0]  sticky_flags_o;
  logic            res_err_o;
  logic            busy_o;

  matmul_sequencer #(
    .DATA_WIDTH      (8),
    .BUS_WIDTH       (16),
    .WATCHDOG_CYCLES (32)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_n_dim_i    (cmd_n_dim_i),
    .cmd_k_dim_i    (cmd_k_dim_i),
    .cmd_m_dim_i    (cmd_m_dim_i),
    .cmd_mode_i     (cmd_mode_i),
    .mul_start_o    (mul_start_o),
    .mul_mode_bit_o (mul_mode_bit_o),
    .mul_n_dim_o    (mul_n_dim_o),
    .mul_k_dim_o    (mul_k_dim_o),
    .mul_m_dim_o    (mul_m_dim_o),
    .mul_finish_i   (mul_finish_i),
    .mul_flags_i    (mul_flags_i),
    .mul_c_matrix_i (mul_c_matrix_i),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready_i),
    .res_c_matrix_o (res_c_matrix_o),
    .res_flags_o    (res_flags_o),
    .sticky_flags_o (sticky_flags_o),
    .res_err_o      (res_err_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0]  c;
    logic [NPE-1:0] f;
    logic           e;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Element (i,j) of a 2x2 matrix sits at index i*2+j, 16 bits each.
  function automatic logic [CW-1:0] pk(input int e0, input int e1, input int e2, input int e3);
    return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endfunction

  function automatic logic [CW-1:0] mm(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                       input logic [CW-1:0] cin, input logic acc);
    logic [CW-1:0] r;
    logic [15:0]   s;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = acc ? cin[(i*2+j)*16 +: 16] : 16'd0;
        for (int k = 0; k < 2; k++) begin
          s = s + 16'(a[(i*2+k)*16 +: 16] * b[(k*2+j)*16 +: 16]);
        end
        r[(i*2+j)*16 +: 16] = s;
      end
    end
    return r;
  endfunction

  // Drive a command for one edge; returns at the negedge after the accept edge.
  task automatic send_cmd(input logic [1:0] n, input logic [1:0] k, input logic [1:0] m,
                          input logic mode);
    cmd_valid_i = 1'b1;
    cmd_n_dim_i = n;
    cmd_k_dim_i = k;
    cmd_m_dim_i = m;
    cmd_mode_i  = mode;
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  // Pulse finish for one edge, then scramble the bus to prove it was captured.
  task automatic do_finish(input logic [CW-1:0] c, input logic [NPE-1:0] f);
    exp_t e;
    e.c = c;
    e.f = f;
    e.e = 1'b0;
    exp_q.push_back(e);
    mul_finish_i   = 1'b1;
    mul_c_matrix_i = c;
    mul_flags_i    = f;
    @(negedge clk);
    mul_finish_i   = 1'b0;
    mul_c_matrix_i = {CW{1'b1}};
    mul_flags_i    = '1;
  endtask

  task automatic push_err();
    exp_t e;
    e.c = '0;
    e.f = '0;
    e.e = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic expect_result(input string tag);
    exp_t e;
    for (int i = 0; i < 64 && !res_valid_o; i++) @(negedge clk);
    chk({tag, "_valid"}, CW'(res_valid_o), CW'(1));
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, CW'(1), CW'(0));
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_c"}, res_c_matrix_o, e.c);
      chk({tag, "_flags"}, CW'(res_flags_o), CW'(e.f));
      chk({tag, "_err"}, CW'(res_err_o), CW'(e.e));
    end
  endtask

  task automatic release_result(input string tag);
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
    chk({tag, "_rel_ready"}, CW'(cmd_ready_o), CW'(1));
    chk({tag, "_rel_valid"}, CW'(res_valid_o), CW'(0));
    chk({tag, "_rel_busy"}, CW'(busy_o), CW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [CW-1:0] a;
    logic [CW-1:0] b;
    logic [CW-1:0] c1;
    logic [CW-1:0] c2;
    int            wait_n;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_ready",  CW'(cmd_ready_o), CW'(1));
    chk("rst_busy",   CW'(busy_o), CW'(0));
    chk("rst_start",  CW'(mul_start_o), CW'(0));
    chk("rst_valid",  CW'(res_valid_o), CW'(0));
    chk("rst_sticky", CW'(sticky_flags_o), CW'(0));
    chk("rst_dims",   CW'({mul_mode_bit_o, mul_n_dim_o, mul_k_dim_o, mul_m_dim_o}), CW'(0));
    chk("rst_res",    res_c_matrix_o, '0);
    rst_ni = 1'b1;
    @(negedge clk);

    // ---------------- basic 2x2x2 overwrite ----------------
    a = pk(1, 2, 3, 4);
    b = pk(5, 6, 7, 8);
    send_cmd(2'd1, 2'd1, 2'd1, 1'b0);
    chk("basic_start", CW'(mul_start_o), CW'(1));
    chk("basic_busy",  CW'(busy_o), CW'(1));
    chk("basic_ready", CW'(cmd_ready_o), CW'(0));
    chk("basic_dims",  CW'({mul_mode_bit_o, mul_n_dim_o, mul_k_dim_o, mul_m_dim_o}), CW'(7'b0_01_01_01));
    repeat (3) @(negedge clk);
    chk("basic_start_hold", CW'(mul_start_o), CW'(1));
    chk("basic_model", mm(a, b, '0, 1'b0), pk(19, 22, 43, 50));
    do_finish(mm(a, b, '0, 1'b0), 4'b0000);
    chk("basic_valid_f1", CW'(res_valid_o), CW'(1));
    chk("basic_start_off", CW'(mul_start_o), CW'(0));
    expect_result("basic");

    // ---------------- backpressure, ignored command, stale finish ----------------
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        chk("bp_cmd_ready", CW'(cmd_ready_o), CW'(0));
        cmd_valid_i = 1'b1;
        cmd_n_dim_i = 2'd0;
        cmd_k_dim_i = 2'd0;
        cmd_m_dim_i = 2'd0;
        cmd_mode_i  = 1'b1;
      end else if (i == 5) begin
        mul_finish_i   = 1'b1;
        mul_c_matrix_i = pk(9, 9, 9, 9);
      end
      @(negedge clk);
      cmd_valid_i  = 1'b0;
      mul_finish_i = 1'b0;
      chk("bp_valid", CW'(res_valid_o), CW'(1));
      chk("bp_data",  res_c_matrix_o, pk(19, 22, 43, 50));
      chk("bp_start", CW'(mul_start_o), CW'(0));
    end
    release_result("bp");
    @(negedge clk);
    chk("bp_ignored_start", CW'(mul_start_o), CW'(0));
    chk("bp_ignored_busy",  CW'(busy_o), CW'(0));

    // ---------------- accumulate chain ----------------
    a = pk(2, 0, 1, 3);
    b = pk(4, 1, 0, 2);
    c1 = mm(a, b, '0, 1'b0);
    send_cmd(2'd1, 2'd1, 2'd1, 1'b0);
    repeat (2) @(negedge clk);
    do_finish(c1, 4'b0001);
    expect_result("acc1");
    chk("acc1_sticky", CW'(sticky_flags_o), CW'(4'b0001));
    release_result("acc1");

    c2 = mm(pk(1, 1, 1, 1), pk(3, 5, 7, 9), c1, 1'b1);
    send_cmd(2'd0, 2'd1, 2'd0, 1'b1);
    chk("acc2_dims", CW'({mul_mode_bit_o, mul_n_dim_o, mul_k_dim_o, mul_m_dim_o}), CW'(7'b1_00_01_00));
    chk("acc2_sticky_kept", CW'(sticky_flags_o), CW'(4'b0001));
    repeat (4) @(negedge clk);
    do_finish(c2, 4'b1000);
    expect_result("acc2");
    chk("acc2_sticky", CW'(sticky_flags_o), CW'(4'b1001));
    release_result("acc2");

    // ---------------- illegal dimension ----------------
    push_err();
    send_cmd(2'd2, 2'd1, 2'd1, 1'b1);
    chk("ill_valid_t1", CW'(res_valid_o), CW'(1));
    chk("ill_start",    CW'(mul_start_o), CW'(0));
    expect_result("ill");
    chk("ill_sticky", CW'(sticky_flags_o), CW'(4'b1001));
    release_result("ill");
    push_err();
    send_cmd(2'd0, 2'd0, 2'd3, 1'b1);
    chk("ill_m_start", CW'(mul_start_o), CW'(0));
    expect_result("ill_m");
    release_result("ill_m");

    // ---------------- third job clears chain ----------------
    send_cmd(2'd1, 2'd1, 2'd1, 1'b0);
    chk("acc3_sticky_clr", CW'(sticky_flags_o), CW'(0));
    @(negedge clk);
    do_finish(mm(a, a, '0, 1'b0), 4'b0000);
    expect_result("acc3");
    chk("acc3_sticky", CW'(sticky_flags_o), CW'(0));
    release_result("acc3");

    // stale finish while idle
    mul_finish_i = 1'b1;
    @(negedge clk);
    mul_finish_i = 1'b0;
    @(negedge clk);
    chk("stale_idle_busy",  CW'(busy_o), CW'(0));
    chk("stale_idle_valid", CW'(res_valid_o), CW'(0));

    // ---------------- reset mid-RUN ----------------
    send_cmd(2'd1, 2'd1, 2'd1, 1'b1);
    repeat (4) @(negedge clk);
    chk("mid_start_pre", CW'(mul_start_o), CW'(1));
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_start", CW'(mul_start_o), CW'(0));
    chk("mid_rst_busy",  CW'(busy_o), CW'(0));
    chk("mid_rst_ready", CW'(cmd_ready_o), CW'(1));
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("mid_post_ready", CW'(cmd_ready_o), CW'(1));
    chk("mid_post_dims",  CW'({mul_mode_bit_o, mul_n_dim_o, mul_k_dim_o, mul_m_dim_o}), CW'(0));
    send_cmd(2'd1, 2'd1, 2'd1, 1'b0);
    repeat (2) @(negedge clk);
    do_finish(mm(pk(3, 1, 4, 1), pk(5, 9, 2, 6), '0, 1'b0), 4'b0010);
    expect_result("mid_job");
    chk("mid_job_c", res_c_matrix_o, pk(17, 33, 22, 42));
    chk("mid_job_sticky", CW'(sticky_flags_o), CW'(4'b0010));
    release_result("mid_job");

    // ---------------- watchdog ----------------
    send_cmd(2'd1, 2'd1, 2'd1, 1'b0);
    chk("wd_start", CW'(mul_start_o), CW'(1));
`ifdef MATMUL_SEQ_WATCHDOG_EN
    push_err();
    wait_n = 0;
    for (int i = 1; i <= 40 && !res_valid_o; i++) begin
      @(negedge clk);
      wait_n = i;
    end
    chk("wd_latency", CW'(wait_n), CW'(33));
    chk("wd_start_off", CW'(mul_start_o), CW'(0));
    expect_result("wd");
    release_result("wd");
`else
    wait_n = 0;
    for (int i = 1; i <= 40 && !res_valid_o; i++) begin
      @(negedge clk);
      wait_n = i;
    end
    chk("nowd_waited", CW'(wait_n), CW'(40));
    chk("nowd_start", CW'(mul_start_o), CW'(1));
    chk("nowd_busy",  CW'(busy_o), CW'(1));
    chk("nowd_valid", CW'(res_valid_o), CW'(0));
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("nowd_exit_ready", CW'(cmd_ready_o), CW'(1));
`endif

    chk("sb_drained", CW'(exp_q.size()), CW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matmul_sequencer.md
# matmul_sequencer

Command-level controller for the systolic matrix-multiply datapath. It accepts one multiply job at a time over a valid/ready command port and drives the multiplier's start, mode and dimension inputs. It waits for the multiplier's finish strobe, captures the result matrix and overflow flags, and presents them on a valid/ready result port. It sits between the register/bus front end and the multiplier, and guarantees the start-low gap the multiplier needs between jobs.

## Interface
- DATA_WIDTH, 8, element width; passed through for result sizing
- BUS_WIDTH, 16, result element width; MAX_DIM = BUS_WIDTH/DATA_WIDTH (localparam)
- WATCHDOG_CYCLES, 32, RUN-state cycle limit; used only with the watchdog macro
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  job request
- cmd_ready_o  out  1  high only in IDLE
- cmd_n_dim_i, cmd_k_dim_i, cmd_m_dim_i  in  2 each  dimension minus 1 (A is NxK, B is KxM)
- cmd_mode_i  in  1  0 = overwrite, 1 = accumulate onto C input
- mul_start_o  out  1  held high for the whole job
- mul_mode_bit_o  out  1  latched cmd_mode_i
- mul_n_dim_o, mul_k_dim_o, mul_m_dim_o  out  2 each  latched dimensions
- mul_finish_i  in  1  finish strobe from the multiplier
- mul_flags_i  in  MAX_DIM*MAX_DIM  per-PE overflow flags
- mul_c_matrix_i  in  MAX_DIM*MAX_DIM*BUS_WIDTH  result matrix
- res_valid_o  out  1  result available
- res_ready_i  in  1  result consumed
- res_c_matrix_o  out  MAX_DIM*MAX_DIM*BUS_WIDTH  captured result
- res_flags_o  out  MAX_DIM*MAX_DIM  captured flags for this job
- sticky_flags_o  out  MAX_DIM*MAX_DIM  OR of flags across an accumulate chain
- res_err_o  out  1  job failed (illegal dimension or watchdog)
- busy_o  out  1  state != IDLE

## Operation
- **States:** IDLE, RUN, DONE. All outputs are registered.
- **IDLE**
  - cmd_ready_o=1.
  - On cmd_valid_i&cmd_ready_o, latch dims and mode.
  - If any dim > MAX_DIM-1: go directly to DONE with res_err_o=1, res_c_matrix_o=0, res_flags_o=0, no start pulse.
  - Otherwise go to RUN.
- **RUN**
  - mul_start_o=1.
  - On mul_finish_i=1: capture mul_c_matrix_i and mul_flags_i into the res_* registers, set res_err_o=0, drop mul_start_o, go to DONE.
- **DONE**
  - res_valid_o=1; all res_* outputs hold stable.
  - On res_ready_i=1, go to IDLE; res_valid_o falls the next cycle.
- **Sticky flags**
  - A mode=0 job clears sticky_flags_o at command accept.
  - Every successful capture ORs in mul_flags_i.
  - Error jobs leave sticky_flags_o unchanged.
- **Start gap:** mul_start_o is low in DONE and IDLE, so there are at least 2 low cycles between jobs. This is sufficient for the multiplier's counter to clear.
- **Mid-job commands:** cmd_valid_i is ignored outside IDLE; no queueing.
- **Stale finish:** mul_finish_i outside RUN is ignored.

## Timing
- **Reset (asynchronous)**
  - State=IDLE, cmd_ready_o=1.
  - Every other output is 0, including mul_* dims and sticky_flags_o.
  - Reset mid-RUN drops mul_start_o immediately.
- **Command accept:** accepted at edge T; mul_start_o=1 from T+1.
- **Finish capture:** mul_finish_i sampled high at edge F; res_valid_o=1 and data are valid from F+1, and mul_start_o=0 from F+1.
- **Illegal dimensions:** accept at T gives res_valid_o=1 at T+1.
- **Back-to-back jobs:** res_ready_i at edge R gives cmd_ready_o=1 from R+1. The earliest next accept is R+1, so minimum job-to-job spacing is 2 cycles of overhead plus the multiplier latency.
- **Concurrent finish:** if res_ready_i and a new mul_finish_i coincide, only the DONE-state behaviour applies; this is impossible by construction.

## Configuration
- **MATMUL_SEQ_WATCHDOG_EN defined**
  - A RUN-cycle counter starts at 0 on entering RUN.
  - If it reaches WATCHDOG_CYCLES without mul_finish_i: drop mul_start_o, go to DONE with res_err_o=1, res_c_matrix_o=0, res_flags_o=0.
  - If mul_finish_i arrives in the same cycle as the limit, finish wins.
- **Undefined**
  - No counter is built; RUN waits indefinitely.
  - res_err_o is driven only by the illegal-dimension check.

## Test plan
- **Basic 2x2x2, overwrite:** MAX_DIM=2, dims=1/1/1, mode=0, A=[1,2;3,4], B=[5,6;7,8]. Expect mul_start_o high from T+1; after finish, res_c_matrix_o=[19,22;43,50], res_flags_o=0, res_err_o=0, res_valid_o one cycle after finish.
- **Illegal dimension:** cmd_n_dim_i=2 with MAX_DIM=2. Expect res_valid_o at T+1, res_err_o=1, mul_start_o never asserted.
- **Backpressure and ignored command:** hold res_ready_i=0 for 10 cycles after finish. Expect res_valid_o and data stable throughout. Pulse cmd_valid_i during this window; expect cmd_ready_o=0 and the command ignored.
- **Accumulate chain:** job 1 (mode=0) produces flag bit0=1; job 2 (mode=1) produces flag bit3=1. Expect sticky_flags_o=4'b1001. A third job with mode=0 and no overflow gives sticky_flags_o=0.
- **Reset mid-RUN:** assert rst_ni=0 five cycles into RUN. Expect mul_start_o=0 and busy_o=0 immediately, with no clock edge needed. After release, cmd_ready_o=1, and a fresh job completes with correct results.
- **Watchdog (MATMUL_SEQ_WATCHDOG_EN, WATCHDOG_CYCLES=32):** tie mul_finish_i=0. Expect res_err_o=1 and res_valid_o=1 thirty-three cycles after start rises. Without the macro, the sequencer stays in RUN.
